// File: rtl/video_timing_analyzer.sv
// Receive-side video timing analyzer: measures line/frame geometry and an active-pixel
// checksum from a pixel-rate video stream, tracks lock, and exposes results on a byte read port.
module video_timing_analyzer #(
  parameter int HS_ACTIVE_LOW = 1,
  parameter int VS_ACTIVE_LOW = 0,
  parameter int LOCK_FRAMES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       h_blank,
  input  logic       h_sync,
  input  logic       v_blank,
  input  logic       v_sync,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       locked,
  output logic       frame_valid,
  output logic       frame_strobe
);

  typedef enum logic [1:0] {SEARCH, MEASURE, TRACK} state_t;

  localparam logic       HS_LVL = (HS_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic       VS_LVL = (VS_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  state_t      state_q;
  logic        hb_prev_q, vb_prev_q;
  logic [11:0] hcnt_q, hcnt_d, hact_q, hact_d, hsw_q, hsw_d;
  logic [11:0] line_total_q, line_total_d, line_active_q, line_active_d, line_sync_q, line_sync_d;
  logic [9:0]  vcnt_q, vcnt_d, vact_q, vact_d, vsw_q, vsw_d;
  logic [15:0] cksum_q, cksum_d;
  logic        hsat_acc_q, hsat_acc_d, vsat_acc_q, vsat_acc_d;
  logic [11:0] htotal_q, hactive_q, ref_htotal_q, ref_hactive_q;
  logic [9:0]  vtotal_q, vactive_q, ref_vtotal_q, ref_vactive_q;
  logic [7:0]  hsync_q, vsync_q, frame_count_q, rd_data_q;
  logic [15:0] cksum_sh_q;
  logic        hsat_q, vsat_q;
  logic [3:0]  match_cnt_q;
  logic        locked_q, frame_valid_q, frame_strobe_q;

  logic        hs_act, vs_act, ls, fs;
  logic        hsat_now, vsat_now, hsat_frame, vsat_frame, timing_same;
  logic [9:0]  pix_sum;
  logic [15:0] pix_add;
  logic [7:0]  hsync_sat, vsync_sat, rd_mux;
  logic [3:0]  match_inc;

  function automatic logic [11:0] inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [9:0] inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  always_comb begin
    hs_act  = (h_sync == HS_LVL);
    vs_act  = (v_sync == VS_LVL);
    // Edges are judged between consecutive pixel samples, not raw clocks.
    ls      = ce_pix & hb_prev_q & ~h_blank;
    fs      = ce_pix & vb_prev_q & ~v_blank;
    pix_sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
    pix_add = (!h_blank && !v_blank) ? {6'b0, pix_sum} : 16'h0000;

    hcnt_d = hcnt_q;   hact_d = hact_q;   hsw_d = hsw_q;
    line_total_d = line_total_q; line_active_d = line_active_q; line_sync_d = line_sync_q;
    vcnt_d = vcnt_q;   vact_d = vact_q;   vsw_d = vsw_q;
    cksum_d = cksum_q;
    hsat_now = 1'b0;   vsat_now = 1'b0;
    hsat_acc_d = hsat_acc_q; vsat_acc_d = vsat_acc_q;

    if (ce_pix) begin
      if (ls) begin
        line_total_d  = hcnt_q;
        line_active_d = hact_q;
        line_sync_d   = hsw_q;
        hcnt_d = 12'd1;
        hact_d = 12'd1;
        hsw_d  = {11'b0, hs_act};
      end else begin
        hcnt_d = inc12(hcnt_q);
        hact_d = h_blank ? hact_q : inc12(hact_q);
        hsw_d  = hs_act ? inc12(hsw_q) : hsw_q;
      end
      if (fs) begin
        vcnt_d = 10'd1;
        vact_d = 10'd1;
        vsw_d  = {9'b0, vs_act};
      end else if (ls) begin
        vcnt_d = inc10(vcnt_q);
        vact_d = v_blank ? vact_q : inc10(vact_q);
        vsw_d  = vs_act ? inc10(vsw_q) : vsw_q;
      end
      cksum_d    = fs ? pix_add : cksum_q + pix_add;
      hsat_now   = (hcnt_d == 12'hFFF);
      vsat_now   = (vcnt_d == 10'h3FF);
      hsat_acc_d = fs ? hsat_now : (hsat_acc_q | hsat_now);
      vsat_acc_d = fs ? vsat_now : (vsat_acc_q | vsat_now);
    end

    // Values describing the frame that ends on this FS sample.
    hsat_frame  = hsat_acc_q | hsat_now;
    vsat_frame  = vsat_acc_q | vsat_now;
    hsync_sat   = (line_sync_d > 12'd255) ? 8'hFF : line_sync_d[7:0];
    vsync_sat   = (vsw_q > 10'd255) ? 8'hFF : vsw_q[7:0];
    timing_same = (line_total_d == ref_htotal_q) && (line_active_d == ref_hactive_q) &&
                  (vcnt_q == ref_vtotal_q) && (vact_q == ref_vactive_q);
    match_inc   = (match_cnt_q == 4'hF) ? 4'hF : match_cnt_q + 4'd1;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (rd_addr)
      4'h0: rd_mux = htotal_q[7:0];
      4'h1: rd_mux = {4'b0, htotal_q[11:8]};
      4'h2: rd_mux = hactive_q[7:0];
      4'h3: rd_mux = {4'b0, hactive_q[11:8]};
      4'h4: rd_mux = hsync_q;
      4'h5: rd_mux = vtotal_q[7:0];
      4'h6: rd_mux = {6'b0, vtotal_q[9:8]};
      4'h7: rd_mux = vactive_q[7:0];
      4'h8: rd_mux = {6'b0, vactive_q[9:8]};
      4'h9: rd_mux = vsync_q;
      4'hA: rd_mux = cksum_sh_q[7:0];
      4'hB: rd_mux = cksum_sh_q[15:8];
      4'hC: rd_mux = frame_count_q;
      4'hD: rd_mux = {4'b0, hsat_q, vsat_q, frame_valid_q, locked_q};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      hb_prev_q <= 1'b0; vb_prev_q <= 1'b0;
      hcnt_q <= '0; hact_q <= '0; hsw_q <= '0;
      line_total_q <= '0; line_active_q <= '0; line_sync_q <= '0;
      vcnt_q <= '0; vact_q <= '0; vsw_q <= '0;
      cksum_q <= '0; hsat_acc_q <= 1'b0; vsat_acc_q <= 1'b0;
      htotal_q <= '0; hactive_q <= '0; hsync_q <= '0;
      vtotal_q <= '0; vactive_q <= '0; vsync_q <= '0;
      cksum_sh_q <= '0; hsat_q <= 1'b0; vsat_q <= 1'b0; frame_count_q <= '0;
      ref_htotal_q <= '0; ref_hactive_q <= '0; ref_vtotal_q <= '0; ref_vactive_q <= '0;
      match_cnt_q <= '0;
      locked_q <= 1'b0; frame_valid_q <= 1'b0; frame_strobe_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (ce_pix) begin
        hb_prev_q <= h_blank;
        vb_prev_q <= v_blank;
      end
      hcnt_q <= hcnt_d; hact_q <= hact_d; hsw_q <= hsw_d;
      line_total_q <= line_total_d; line_active_q <= line_active_d; line_sync_q <= line_sync_d;
      vcnt_q <= vcnt_d; vact_q <= vact_d; vsw_q <= vsw_d;
      cksum_q <= cksum_d; hsat_acc_q <= hsat_acc_d; vsat_acc_q <= vsat_acc_d;
      frame_strobe_q <= 1'b0;
      rd_data_q <= rd_mux;

      if (fs) begin
        case (state_q)
          SEARCH: state_q <= MEASURE;
          MEASURE, TRACK: begin
            htotal_q   <= line_total_d;
            hactive_q  <= line_active_d;
            hsync_q    <= hsync_sat;
            vtotal_q   <= vcnt_q;
            vactive_q  <= vact_q;
            vsync_q    <= vsync_sat;
            cksum_sh_q <= cksum_q;
            hsat_q     <= hsat_frame;
            vsat_q     <= vsat_frame;
            frame_count_q  <= frame_count_q + 8'd1;
            frame_strobe_q <= 1'b1;
            frame_valid_q  <= 1'b1;
            ref_htotal_q   <= line_total_d;
            ref_hactive_q  <= line_active_d;
            ref_vtotal_q   <= vcnt_q;
            ref_vactive_q  <= vact_q;
            if (state_q == TRACK && timing_same && !hsat_frame && !vsat_frame) begin
              match_cnt_q <= match_inc;
              locked_q    <= (match_inc >= LOCK_N);
            end else begin
              match_cnt_q <= 4'd1;
              locked_q    <= (state_q == MEASURE) && !hsat_frame && !vsat_frame && (LOCK_N <= 4'd1);
            end
            state_q <= TRACK;
          end
          default: state_q <= SEARCH;
        endcase
      end

      // A runaway counter means the timing is not trustworthy right now.
      if (hsat_now || vsat_now) locked_q <= 1'b0;
    end
  end

  assign rd_data      = rd_data_q;
  assign locked       = locked_q;
  assign frame_valid  = frame_valid_q;
  assign frame_strobe = frame_strobe_q;

endmodule
